// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Execute-stage controller in front of a WIDTH-bit ALU.
//                Registers the ALU operands/op, runs single-pass ops in one
//                cycle and shift-class ops (op[4:2]==3'b111) for in_count
//                passes by feeding Q back into B, then holds the result and
//                flags for a valid/ready writeback handshake.
//                Optional feature macro: ALU_SEQ_BYPASS_EN (accept the next
//                command in DONE on the same edge as the writeback handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [4:0]         in_op,
    input  logic [COUNT_W-1:0] in_count,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [4:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_q,
    input  logic               alu_overflow,
    input  logic               alu_less,
    input  logic               alu_equal,
    input  logic               alu_greater,
    input  logic               alu_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_q,
    output logic [4:0]         flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q,   state_d;
    logic [WIDTH-1:0]   alu_a_q,   alu_a_d;
    logic [WIDTH-1:0]   alu_b_q,   alu_b_d;
    logic [4:0]         alu_op_q,  alu_op_d;
    logic [COUNT_W-1:0] rem_q,     rem_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    logic [4:0]         flags_q,   flags_d;

    logic               w_can_accept;
    logic               w_start;
    logic               w_is_shift;

    // Decide whether a new command may be taken this cycle.
    always_comb begin
        w_can_accept = 1'b0;
        case (state_q)
            S_IDLE:  w_can_accept = 1'b1;
`ifdef ALU_SEQ_BYPASS_EN
            // Result leaves on this edge, so the slot frees up immediately.
            S_DONE:  w_can_accept = out_ready;
`else
            S_DONE:  w_can_accept = 1'b0;
`endif
            default: w_can_accept = 1'b0;
        endcase
    end

    assign in_ready   = w_can_accept;
    assign w_start    = in_valid && w_can_accept;
    assign w_is_shift = (in_op[4:2] == 3'b111);

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        rem_d     = rem_q;
        ovf_acc_d = ovf_acc_q;
        result_d  = result_q;
        flags_d   = flags_q;

        case (state_q)
            S_EXEC: begin
                result_d = alu_q;
                flags_d  = {alu_overflow, alu_less, alu_equal, alu_greater, alu_zero};
                state_d  = S_DONE;
            end
            S_ITER: begin
                // Feed this pass's result back as the next pass's operand.
                alu_b_d   = alu_q;
                result_d  = alu_q;
                rem_d     = rem_q - COUNT_W'(1);
                ovf_acc_d = ovf_acc_q | alu_overflow;
                if (rem_q == COUNT_W'(1)) begin
                    flags_d = {ovf_acc_q | alu_overflow, alu_less, alu_equal,
                               alu_greater, alu_zero};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // A newly accepted command overrides the DONE->IDLE return.
        if (w_start) begin
            alu_a_d   = in_a;
            alu_b_d   = in_b;
            alu_op_d  = in_op;
            rem_d     = in_count;
            ovf_acc_d = 1'b0;
            if (!w_is_shift) begin
                state_d = S_EXEC;
            end else if (in_count != '0) begin
                state_d = S_ITER;
            end else begin
                // Zero-length shift: result is B unchanged, only zero is meaningful.
                result_d = in_b;
                flags_d  = {4'b0000, ~|in_b};
                state_d  = S_DONE;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            rem_q     <= '0;
            ovf_acc_q <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            rem_q     <= rem_d;
            ovf_acc_q <= ovf_acc_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign out_q     = result_q;
    assign flags     = flags_q;
    assign out_valid = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Directed self-checking bench for alu_sequencer with a small
//                behavioural ALU (ADD, SUB/compare, AND, logical right shift).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int WIDTH   = 16;
    localparam int COUNT_W = 4;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [4:0]         in_op;
    logic [COUNT_W-1:0] in_count;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [4:0]         alu_op;
    logic [WIDTH-1:0]   alu_q;
    logic               alu_overflow;
    logic               alu_less;
    logic               alu_equal;
    logic               alu_greater;
    logic               alu_zero;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_q;
    logic [4:0]         flags;

    int n_checks = 0;
    int n_errors = 0;

    alu_sequencer #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .in_count     (in_count),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_q        (alu_q),
        .alu_overflow (alu_overflow),
        .alu_less     (alu_less),
        .alu_equal    (alu_equal),
        .alu_greater  (alu_greater),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_q        (out_q),
        .flags        (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: ADD(00001) carry->overflow, SUB(00010) with compare
    // flags and borrow->overflow, AND(00011), LSR(11100) bit-out->overflow.
    always_comb begin
        logic [WIDTH:0] sum;
        sum          = '0;
        alu_q        = alu_a;
        alu_overflow = 1'b0;
        alu_less     = 1'b0;
        alu_equal    = 1'b0;
        alu_greater  = 1'b0;
        case (alu_op)
            5'b00001: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_q        = sum[WIDTH-1:0];
                alu_overflow = sum[WIDTH];
            end
            5'b00010: begin
                alu_q        = alu_a - alu_b;
                alu_overflow = (alu_a < alu_b);
                alu_less     = (alu_a < alu_b);
                alu_equal    = (alu_a == alu_b);
                alu_greater  = (alu_a > alu_b);
            end
            5'b00011: alu_q = alu_a & alu_b;
            5'b11100: begin
                alu_q        = alu_b >> 1;
                alu_overflow = alu_b[0];
            end
            default: alu_q = alu_a;
        endcase
        alu_zero = (alu_q == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a command while the sequencer is idle; returns after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] op, input logic [3:0] cnt);
        in_a = a; in_b = b; in_op = op; in_count = cnt; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // One writeback beat, then confirm the result is gone.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Full directed transaction: issue, check latency, result, flags, busy.
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] op, input logic [3:0] cnt,
                       input int exp_lat, input logic [15:0] exp_q, input logic [4:0] exp_f);
        int lat;
        issue(a, b, op, cnt);
        wait_valid(lat);
        check({tag, "_lat"},   lat,   exp_lat);
        check({tag, "_q"},     {16'd0, out_q}, {16'd0, exp_q});
        check({tag, "_flags"}, {27'd0, flags}, {27'd0, exp_f});
        check({tag, "_busy"},  {31'd0, in_ready}, 32'd0);
        check({tag, "_alu_a"}, {16'd0, alu_a}, {16'd0, a});
        drain(tag);
    endtask

    initial begin
        int lat;
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_a = 16'h1111; in_b = 16'h2222; in_op = 5'b00001; in_count = 4'd0;

        // Reset held two cycles with a command present.
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_flags",     {27'd0, flags},     32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_q",     {16'd0, out_q},     32'd0);
        check("rst_alu_a",     {16'd0, alu_a},     32'd0);
        check("rst_alu_op",    {27'd0, alu_op},    32'd0);

        run("add_wrap",  16'hFFFF, 16'h0001, 5'b00001, 4'd0, 1, 16'h0000, 5'b10001);
        // Flags are architectural: still visible while idle.
        check("flags_hold_idle", {27'd0, flags}, {27'd0, 5'b10001});
        run("sub_gt",    16'h0005, 16'h0003, 5'b00010, 4'd0, 1, 16'h0002, 5'b00010);
        run("sub_eq",    16'h0007, 16'h0007, 5'b00010, 4'd0, 1, 16'h0000, 5'b00101);
        run("and",       16'hF0F0, 16'h3C3C, 5'b00011, 4'd0, 1, 16'h3030, 5'b00000);
        run("lsr3",      16'h0000, 16'h0010, 5'b11100, 4'd3, 3, 16'h0002, 5'b00000);
        run("lsr_sticky",16'h0000, 16'h0003, 5'b11100, 4'd2, 2, 16'h0000, 5'b10001);
        run("lsr1",      16'h0000, 16'h0005, 5'b11100, 4'd1, 1, 16'h0002, 5'b10000);
        run("lsr15",     16'h0000, 16'hFFFF, 5'b11100, 4'd15, 15, 16'h0001, 5'b10000);

        // Count 0 under backpressure, with a competing command that must be ignored.
        issue(16'h1234, 16'h8000, 5'b11100, 4'd0);
        check("cnt0_lat", {31'd0, out_valid}, 32'd1);
        in_a = 16'h0001; in_b = 16'h0001; in_op = 5'b00001; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_q",      {16'd0, out_q},    32'h8000);
            check("bp_valid",  {31'd0, out_valid}, 32'd1);
            check("bp_ready",  {31'd0, in_ready},  32'd0);
            check("bp_alu_a",  {16'd0, alu_a},    32'h1234);
        end
        in_valid = 1'b0;
        check("cnt0_flags", {27'd0, flags}, 32'd0);
        drain("bp");

        // Reset during a long shift: nothing must come out.
        issue(16'h0000, 16'h0400, 5'b11100, 4'd10);
        @(posedge clk); @(posedge clk); #1;
        check("iter_alu_b", {16'd0, alu_b}, 32'h0100);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ready", {31'd0, in_ready},  32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) check("midrst_spurious", {31'd0, out_valid}, 32'd0);
        end
        run("post_rst_add", 16'h0002, 16'h0003, 5'b00001, 4'd0, 1, 16'h0005, 5'b00000);

        // Wait with a bound even on an idle DUT, confirming no stray result.
        wait_valid(lat);
        check("idle_no_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
